// File: rtl/pool_pkg.sv
// Shared defaults and row-state encoding for the ReLU + 2x2 max-pool stage.
package pool_pkg;

    localparam int N_DEF    = 16;
    localparam int FM_W_DEF = 26;
    localparam int FM_H_DEF = 26;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } row_state_e;

    // Counter/address width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width row buffer holding top-row pair maxima until the bottom row arrives.
module pool_line_buf #(
    parameter int N     = 16,
    parameter int DEPTH = 13,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-order feature map.
module relu_maxpool
    import pool_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FM_W = FM_W_DEF,
    parameter int FM_H = FM_H_DEF
) (
    input  logic         clk,
    input  logic         global_rst,
    input  logic         ce,
    input  logic [N-1:0] conv_op,
    input  logic         valid_conv,
    input  logic         end_conv,
    output logic [N-1:0] pool_op,
    output logic         valid_op,
    output logic         end_op
);

    localparam int CW    = cnt_w(FM_W);
    localparam int RW    = cnt_w(FM_H);
    localparam int DEPTH = FM_W / 2;
    localparam int AW    = cnt_w(DEPTH);

    localparam logic [CW-1:0] COL_LAST = CW'(FM_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FM_H - 1);

    if ((FM_W % 2) != 0 || (FM_H % 2) != 0 || FM_W < 2 || FM_H < 2) begin : g_bad_dims
        $error("relu_maxpool: FM_W and FM_H must be even and at least 2");
    end

    function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    row_state_e    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [N-1:0]  pool_q, pool_d;
    logic          valid_q, valid_d;
    logic          end_q, end_d;

    logic [N-1:0]  x_relu;
    logic          accept;
    logic          abort;
    logic          last_col;
    logic          last_row;
    logic          lb_we;
    logic [AW-1:0] lb_addr;
    logic [N-1:0]  lb_wdata;
    logic [N-1:0]  lb_rdata;

    assign x_relu   = conv_op[N-1] ? '0 : conv_op;
    assign accept   = ce & valid_conv & ~end_conv;
    assign abort    = ce & end_conv & ((col_q != '0) | (row_q != '0));
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    assign lb_addr  = AW'(col_q >> 1);
    assign lb_wdata = smax(hold_q, x_relu);

    pool_line_buf #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (lb_wdata),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (global_rst) begin
            state_q <= EVEN_ROW;
            col_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
            pool_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
            pool_q  <= pool_d;
            valid_q <= valid_d;
            end_q   <= end_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        hold_d  = hold_q;
        pool_d  = pool_q;
        valid_d = valid_q;
        end_d   = end_q;
        lb_we   = 1'b0;

        if (ce) begin
            valid_d = 1'b0;
            end_d   = 1'b0;

            if (abort) begin
                state_d = EVEN_ROW;
                col_d   = '0;
                row_d   = '0;
                hold_d  = '0;
            end else if (accept) begin
                unique case (state_q)
                    EVEN_ROW: begin
                        if (!col_q[0]) begin
                            hold_d = x_relu;
                        end else begin
                            lb_we = 1'b1;
                        end
                    end
                    ODD_ROW: begin
                        if (!col_q[0]) begin
                            hold_d = smax(lb_rdata, x_relu);
                        end else begin
                            pool_d  = smax(hold_q, x_relu);
                            valid_d = 1'b1;
                            end_d   = last_col & last_row;
                        end
                    end
                endcase

                // Row wrap also flips the window half and wraps the frame.
                if (last_col) begin
                    col_d   = '0;
                    row_d   = last_row ? '0 : row_q + 1'b1;
                    state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    // A pulse raised just before a stall stays pending until ce returns.
    assign pool_op  = pool_q;
    assign valid_op = valid_q & ce;
    assign end_op   = end_q & ce;

endmodule

// File: tb/tb_relu_maxpool.sv
// Scoreboard bench for relu_maxpool: random and directed frames vs a frame-array model.
module tb_relu_maxpool;

    localparam int N    = 16;
    localparam int W    = 26;
    localparam int H    = 26;
    localparam int FS   = W * H;
    localparam int NOUT = (W / 2) * (H / 2);

    logic         clk = 1'b0;
    logic         global_rst;
    logic         ce;
    logic [N-1:0] conv_op;
    logic         valid_conv;
    logic         end_conv;
    logic [N-1:0] pool_op;
    logic         valid_op;
    logic         end_op;

    always #5 clk = ~clk;

    relu_maxpool #(
        .N    (N),
        .FM_W (W),
        .FM_H (H)
    ) dut (
        .clk        (clk),
        .global_rst (global_rst),
        .ce         (ce),
        .conv_op    (conv_op),
        .valid_conv (valid_conv),
        .end_conv   (end_conv),
        .pool_op    (pool_op),
        .valid_op   (valid_op),
        .end_op     (end_op)
    );

    typedef struct {
        int val;
        bit last;
        int en;
    } exp_t;

    exp_t sbq[$];
    int   got[$];
    int   got_ends;
    int   ntests = 0;
    int   nfail  = 0;
    int   en_cnt = 0;
    int   k      = 0;
    int   fr[FS];

    function automatic int relu(input logic [N-1:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) ? 0 : s;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int ramp_expect(input int j);
        return (2 * (j / (W / 2)) + 1) * W + 2 * (j % (W / 2)) + 1;
    endfunction

    task automatic check(input string name, input int act, input int req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock of stimulus; the model sees exactly what the DUT sampled.
    task automatic step(input logic r, input logic c, input logic v,
                        input logic e, input logic [N-1:0] x);
        int rr;
        int cc;
        global_rst = r;
        ce         = c;
        valid_conv = v;
        end_conv   = e;
        conv_op    = x;
        @(posedge clk);
        if (r) begin
            k = 0;
        end else if (c) begin
            en_cnt++;
            if (e) begin
                k = 0;
            end else if (v) begin
                fr[k] = relu(x);
                rr = k / W;
                cc = k % W;
                if ((rr % 2) == 1 && (cc % 2) == 1) begin
                    sbq.push_back('{max4(fr[k-W-1], fr[k-W], fr[k-1], fr[k]),
                                    (k == FS - 1), en_cnt});
                end
                k = (k + 1) % FS;
            end
        end
        #1;
    endtask

    task automatic feed(input int x);
        step(1'b0, 1'b1, 1'b1, 1'b0, N'(x));
    endtask

    task automatic ramp();
        for (int i = 0; i < FS; i++) feed(i);
    endtask

    task automatic start();
        got.delete();
        got_ends = 0;
    endtask

    task automatic drain(input string name);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        check({name, " pending"}, sbq.size(), 0);
    endtask

    task automatic check_ramp(input string name, input int base);
        int bad;
        bad = 0;
        for (int j = 0; j < NOUT; j++) begin
            if (base + j >= got.size() || got[base + j] != ramp_expect(j)) bad++;
        end
        check({name, " ramp seq errors"}, bad, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid_op === 1'b1) begin
            got.push_back(int'(pool_op));
            if (end_op === 1'b1) got_ends++;
            if (ce !== 1'b1) begin
                ntests++;
                nfail++;
                $display("FAIL stall_valid: valid_op=1 while ce=%b", ce);
            end
            if (sbq.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_out: got %0d, expected no output", pool_op);
            end else begin
                e = sbq.pop_front();
                check("pool_op", int'($signed(pool_op)), e.val);
                check("end_op", int'(end_op), int'(e.last));
                check("latency", en_cnt, e.en);
            end
        end else if (end_op === 1'b1) begin
            ntests++;
            nfail++;
            $display("FAIL end_alone: end_op=1, expected 0 without valid_op");
        end
    end

    initial begin
        int done;
        logic c;
        logic v;

        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h1234);
        ce = 1'b1;
        #1;
        check("rst pool_op", int'(pool_op), 0);
        check("rst valid_op", int'(valid_op), 0);
        check("rst end_op", int'(end_op), 0);

        start();
        ramp();
        drain("ramp");
        check("ramp count", got.size(), NOUT);
        check("ramp ends", got_ends, 1);
        check("ramp first", got.size() > 0 ? got[0] : -1, 27);
        check("ramp 13th", got.size() > 12 ? got[12] : -1, 51);
        check("ramp 14th", got.size() > 13 ? got[13] : -1, 79);
        check("ramp last", got.size() > 0 ? got[got.size()-1] : -1, 675);
        check_ramp("ramp", 0);

        start();
        for (int i = 0; i < FS; i++) feed(-5);
        drain("relu");
        check("relu count", got.size(), NOUT);
        check("relu first", got.size() > 0 ? got[0] : -1, 0);

        start();
        for (int i = 0; i < FS; i++) begin
            if ((i / W) % 2 == 0) feed(((i % W) % 2 == 0) ? 100 : -3);
            else feed(((i % W) % 2 == 0) ? 7 : 2);
        end
        drain("window");
        check("window count", got.size(), NOUT);
        check("window last", got.size() > 0 ? got[got.size()-1] : -1, 100);

        start();
        for (int i = 0; i < FS; i++) begin
            feed(i);
            if (i == 300) repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, 16'h7FFF);
            if (i % 7 == 6) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF);
        end
        drain("stall");
        check("stall count", got.size(), NOUT);
        check_ramp("stall", 0);

        for (int i = 0; i <= 100; i++) feed(i);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        drain("abort_rst partial");
        start();
        ramp();
        drain("abort_rst");
        check("abort_rst count", got.size(), NOUT);
        check_ramp("abort_rst", 0);

        for (int i = 0; i <= 100; i++) feed(i);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'd999);
        drain("abort_end partial");
        start();
        ramp();
        drain("abort_end");
        check("abort_end count", got.size(), NOUT);
        check_ramp("abort_end", 0);

        start();
        ramp();
        ramp();
        drain("b2b");
        check("b2b count", got.size(), 2 * NOUT);
        check("b2b ends", got_ends, 2);
        check("b2b second first", got.size() > NOUT ? got[NOUT] : -1, 27);
        check_ramp("b2b f2", NOUT);

        start();
        done = 0;
        while (done < 3 * FS) begin
            c = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 3) != 0);
            step(1'b0, c, v, 1'b0, N'($urandom));
            if (c && v) done++;
        end
        drain("random");
        check("random count", got.size(), 3 * NOUT);
        check("random ends", got_ends, 3);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
